// File: rtl/operator_slot_sequencer_if.sv
// Slot-strobe bus between the frame scheduler and the operator pipeline.
// The master drives frame requests; the slave (the sequencer) drives strobes and envelope timing.
interface operator_slot_sequencer_if #(
   parameter int unsigned NUM_BANKS              = 2,
   parameter int unsigned NUM_OPERATORS_PER_BANK = 18,
   parameter int unsigned EG_TIMER_WIDTH         = 36
);
   localparam int unsigned BANK_NUM_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned OP_NUM_WIDTH   =
      (NUM_OPERATORS_PER_BANK > 1) ? $clog2(NUM_OPERATORS_PER_BANK) : 1;

   logic                      sample_tick;
   logic                      overrun_clr;
   logic                      slot_en;
   logic [BANK_NUM_WIDTH-1:0] bank_num;
   logic [OP_NUM_WIDTH-1:0]   op_num;
   logic                      frame_busy;
   logic                      frame_done;
   logic                      overrun;
   logic [EG_TIMER_WIDTH-1:0] eg_timer;
   logic [3:0]                eg_add;

   modport master (
      output sample_tick, overrun_clr,
      input  slot_en, bank_num, op_num, frame_busy, frame_done, overrun, eg_timer, eg_add
   );

   modport slave (
      input  sample_tick, overrun_clr,
      output slot_en, bank_num, op_num, frame_busy, frame_done, overrun, eg_timer, eg_add
   );
endinterface

// File: rtl/operator_slot_sequencer.sv
// Per-sample frame scheduler: strobes every bank/op slot once per sample tick, spaced so the
// envelope read-modify-write pipeline never overlaps on one address, and owns the envelope timer.
module operator_slot_sequencer #(
   parameter int unsigned NUM_BANKS              = 2,
   parameter int unsigned NUM_OPERATORS_PER_BANK = 18,
   parameter int unsigned SLOT_GAP               = 4,
   parameter int unsigned DRAIN_CYCLES           = 4,
   parameter int unsigned EG_TIMER_WIDTH         = 36
) (
   input logic                      clk,
   input logic                      reset_n,
   operator_slot_sequencer_if.slave bus
);
   localparam int unsigned BANK_NUM_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned OP_NUM_WIDTH   =
      (NUM_OPERATORS_PER_BANK > 1) ? $clog2(NUM_OPERATORS_PER_BANK) : 1;
   localparam int unsigned DRAIN_WIDTH    = $clog2(DRAIN_CYCLES + 1);

   localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK  = BANK_NUM_WIDTH'(NUM_BANKS - 1);
   localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP    = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
   localparam logic [3:0]                GAP_LOAD   = 4'(SLOT_GAP - 2);
   localparam logic [DRAIN_WIDTH-1:0]    DRAIN_LOAD = DRAIN_WIDTH'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StGap, StDrain} state_e;

   state_e                    state_q;
   logic                      slot_en_q;
   logic                      frame_busy_q;
   logic                      frame_done_q;
   logic                      overrun_q;
   logic                      eg_odd_q;
   logic [BANK_NUM_WIDTH-1:0] bank_num_q;
   logic [OP_NUM_WIDTH-1:0]   op_num_q;
   logic [EG_TIMER_WIDTH-1:0] eg_timer_q;
   logic [3:0]                eg_add_q;
   logic [3:0]                gap_cnt_q;
   logic [DRAIN_WIDTH-1:0]    drain_cnt_q;

   logic [EG_TIMER_WIDTH-1:0] eg_timer_next;
   logic [3:0]                eg_add_next;
   logic                      start_frame;
   logic                      last_slot;

   // Index of the lowest set bit plus one; zero when no bit is set.
   function automatic logic [3:0] rate_shift(input logic [12:0] t);
      rate_shift = 4'd0;
      for (int i = 12; i >= 0; i--) begin
         if (t[i]) rate_shift = 4'(i + 1);
      end
   endfunction

   always_comb begin
      eg_timer_next = eg_timer_q + EG_TIMER_WIDTH'(eg_odd_q);
      eg_add_next   = rate_shift(eg_timer_next[12:0]);
      // A tick in the done cycle chains straight into the next frame.
      start_frame   = bus.sample_tick && ((state_q == StIdle) || frame_done_q);
      last_slot     = (bank_num_q == LAST_BANK) && (op_num_q == LAST_OP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         slot_en_q    <= 1'b0;
         frame_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         eg_odd_q     <= 1'b0;
         bank_num_q   <= '0;
         op_num_q     <= '0;
         eg_timer_q   <= '0;
         eg_add_q     <= 4'd0;
         gap_cnt_q    <= 4'd0;
         drain_cnt_q  <= '0;
      end else begin
         slot_en_q    <= 1'b0;
         frame_done_q <= 1'b0;

         if (bus.sample_tick && frame_busy_q && !frame_done_q) begin
            overrun_q <= 1'b1;
         end else if (bus.overrun_clr) begin
            overrun_q <= 1'b0;
         end

         if (start_frame) begin
            state_q      <= StIssue;
            slot_en_q    <= 1'b1;
            frame_busy_q <= 1'b1;
            bank_num_q   <= '0;
            op_num_q     <= '0;
            eg_odd_q     <= ~eg_odd_q;
            eg_timer_q   <= eg_timer_next;
            eg_add_q     <= eg_add_next;
         end else begin
            unique case (state_q)
               StIdle: ;
               StIssue: begin
                  if (last_slot) begin
                     state_q      <= StDrain;
                     drain_cnt_q  <= DRAIN_LOAD;
                     frame_done_q <= (DRAIN_CYCLES == 1);
                  end else begin
                     state_q   <= StGap;
                     gap_cnt_q <= GAP_LOAD;
                  end
               end
               StGap: begin
                  if (gap_cnt_q == 4'd0) begin
                     state_q   <= StIssue;
                     slot_en_q <= 1'b1;
                     if (op_num_q == LAST_OP) begin
                        op_num_q   <= '0;
                        bank_num_q <= bank_num_q + BANK_NUM_WIDTH'(1);
                     end else begin
                        op_num_q <= op_num_q + OP_NUM_WIDTH'(1);
                     end
                  end else begin
                     gap_cnt_q <= gap_cnt_q - 4'd1;
                  end
               end
               StDrain: begin
                  if (frame_done_q) begin
                     state_q      <= StIdle;
                     frame_busy_q <= 1'b0;
                  end else if (drain_cnt_q <= DRAIN_WIDTH'(1)) begin
                     frame_done_q <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q - DRAIN_WIDTH'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.slot_en    = slot_en_q;
   assign bus.bank_num   = bank_num_q;
   assign bus.op_num     = op_num_q;
   assign bus.frame_busy = frame_busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overrun    = overrun_q;
   assign bus.eg_timer   = eg_timer_q;
   assign bus.eg_add     = eg_add_q;
endmodule
